spm_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 8-bit SPM SRAM between the RISC processor (port 0) and a program loader/DMA engine (port 1). Each requester runs a req/ack handshake. A three-state FSM with round-robin fairness serialises their accesses onto the memory's address, data-in, data-out and write nets. The block sits between the requesters and the memory unit, replacing their direct connection.

---
 rtl/spm_pkg.sv | 13 +
 rtl/spm_rr_pick.sv | 20 ++
 rtl/spm_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_spm_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the SPM memory arbiter: default widths and FSM encoding.
package spm_pkg;

    localparam int unsigned DEF_WORD_SIZE = 8;
    localparam int unsigned DEF_ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/spm_rr_pick.sv
// Two-way round-robin picker: on a tie the port not equal to 'last' wins.
module spm_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/spm_mem_arbiter.sv
// Two-port req/ack arbiter in front of the single-port SPM SRAM.
// Optional locked bursts are compiled in with ARB_LOCK_EN.
module spm_mem_arbiter
    import spm_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
`ifdef ARB_LOCK_EN
    ,
    parameter int unsigned MAX_BURST = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic [WORD_SIZE-1:0] wdata1,
`ifdef ARB_LOCK_EN
    input  logic                 lock0,
    input  logic                 lock1,
`endif
    output logic                 ack0,
    output logic                 ack1,
    output logic [WORD_SIZE-1:0] rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic                 grant
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   pick_valid;
    logic                   pick_winner;
    logic                   sel_we;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [WORD_SIZE-1:0]   sel_wdata;
    logic                   cont;
    logic                   ack0_nxt;
    logic                   ack1_nxt;
    logic                   grant_nxt;
    logic [WORD_SIZE-1:0]   rdata_nxt;

    spm_rr_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (grant),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Fields of the granted requester
    assign sel_we    = grant ? we1    : we0;
    assign sel_addr  = grant ? addr1  : addr0;
    assign sel_wdata = grant ? wdata1 : wdata0;

`ifdef ARB_LOCK_EN
    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_cnt_nxt;
    logic          sel_req;
    logic          sel_lock;

    assign sel_req  = grant ? req1  : req0;
    assign sel_lock = grant ? lock1 : lock0;
    assign cont     = sel_lock && sel_req && (burst_cnt < BW'(MAX_BURST - 1));
`else
    assign cont = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nxt = S_ACC;
            S_ACC:   state_nxt = S_ACK;
            S_ACK:   state_nxt = cont ? S_ACC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory nets are decoded from state so a locked follow-on access sees the
    // requester's freshly updated fields.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        grant_nxt = grant;
        rdata_nxt = rdata;
`ifdef ARB_LOCK_EN
        burst_cnt_nxt = burst_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (pick_valid) grant_nxt = pick_winner;
            end
            S_ACC: begin
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
                mem_write = sel_we;
                rdata_nxt = sel_we ? sel_wdata : mem_rdata;
                ack0_nxt  = ~grant;
                ack1_nxt  = grant;
            end
            S_ACK: begin
`ifdef ARB_LOCK_EN
                burst_cnt_nxt = cont ? burst_cnt + BW'(1) : '0;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            rdata <= '0;
            busy  <= 1'b0;
            grant <= 1'b1;
`ifdef ARB_LOCK_EN
            burst_cnt <= '0;
`endif
        end else begin
            ack0  <= ack0_nxt;
            ack1  <= ack1_nxt;
            rdata <= rdata_nxt;
            busy  <= (state_nxt != S_IDLE);
            grant <= grant_nxt;
`ifdef ARB_LOCK_EN
            burst_cnt <= burst_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_spm_mem_arbiter.sv
// Self-checking bench for spm_mem_arbiter with a behavioural SPM SRAM model.
// Locked-burst sequence runs only when ARB_LOCK_EN is defined.
module tb_spm_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
`ifdef ARB_LOCK_EN
    logic       lock0, lock1;
`endif
    logic       ack0, ack1, mem_write, busy, grant;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    spm_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
`ifdef ARB_LOCK_EN
        .lock0     (lock0),
        .lock1     (lock1),
`endif
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    // SRAM model: combinational read, write on rising edge
    logic [7:0] mem [256];
    logic       mem_init;
    int         wr_cnt;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[8'h10] <= 8'hA5;
            wr_cnt <= 0;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic       port;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_cmp, n_err, cyc;
    logic prev_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any ack against the queue
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (ack0 || ack1) begin
            check("ack_one_hot", 32'(ack0 & ack1), 32'(0));
            check("ack_single_cycle", 32'(prev_ack), 32'(0));
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none (cycle %0d)", ack0, ack1, cyc);
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(ack1), 32'(e.port));
                check("grant_at_ack", 32'(grant), 32'(e.port));
                check("rdata", 32'(rdata), 32'(e.rdata));
            end
        end
        prev_ack = ack0 | ack1;
    endtask

    task automatic do_access(input vec_t v);
        int   lat;
        int   wr0;
        logic seen;
        @(posedge clk); #1;
        wr0 = wr_cnt;
        sb.push_back(exp_t'{port: v.port, rdata: v.exp_rdata});
        if (v.port) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            tick();
            lat++;
            seen = v.port ? ack1 : ack0;
        end
        check("latency", 32'(lat), 32'(3));
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("ack_dropped", 32'({ack0, ack1}), 32'(0));
        check("write_count", 32'(wr_cnt - wr0), 32'(v.we));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        check("reset_grant", 32'({busy, grant}), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        n_cmp = 0; n_err = 0; cyc = 0; prev_ack = 1'b0;
        rst = 1'b1; mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif

        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h3C};
        vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 8'h30, 8'h77, 8'h77};
        vecs[4] = '{1'b1, 1'b0, 8'h30, 8'h00, 8'h77};
        vecs[5] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hA5};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 8'hC3, 8'hC3};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hC3};

        tick();
        tick();
        check("reset_outputs",
              32'({ack0, ack1, rdata, mem_addr, mem_wdata, mem_write, busy, grant}), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        mem_init = 1'b0;

        for (int i = 0; i < 8; i++) do_access(vecs[i]);

        // Both ports hold requests: grants must alternate starting with port 0
        pulse_reset();
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{port: 1'b0, rdata: 8'hA5});
            sb.push_back(exp_t'{port: 1'b1, rdata: 8'h3C});
        end
        n = 0;
        guard = 0;
        while (n < 4 && guard < 40) begin
            tick();
            guard++;
            if (ack0 || ack1) n++;
        end
        check("contention_acks", 32'(n), 32'(4));
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset during the access cycle of a write must suppress the commit
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 8'hFF;
        tick();
        tick();
        check("acc_strobe", 32'({busy, mem_write, mem_addr}), 32'({1'b1, 1'b1, 8'h40}));
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'({busy, mem_write, ack0, ack1, mem_addr}), 32'(0));
        req1 = 1'b0;
        we1 = 1'b0;
        tick();
        tick();
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_mem", 32'(mem[8'h40]), 32'(8'h1A));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_ack", 32'({ack0, ack1}), 32'(0));
        end

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", 32'({busy, mem_write, ack0, ack1}), 32'(0));
        end

`ifdef ARB_LOCK_EN
        begin
            int   n1;
            int   last1;
            logic done0;
            @(posedge clk); #1;
            req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
            for (int i = 0; i < 4; i++) sb.push_back(exp_t'{port: 1'b1, rdata: 8'h3C});
            sb.push_back(exp_t'{port: 1'b0, rdata: 8'hA5});
            @(posedge clk); #1;
            req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
            n1 = 0; last1 = 0; done0 = 1'b0; guard = 0;
            while (!done0 && guard < 40) begin
                tick();
                guard++;
                if (ack1) begin
                    if (n1 > 0) check("lock_spacing", 32'(cyc - last1), 32'(2));
                    last1 = cyc;
                    n1++;
                end
                if (ack0) begin
                    check("lock_burst_len", 32'(n1), 32'(4));
                    done0 = 1'b1;
                end
                @(posedge clk); #1;
                if (n1 == 4) begin
                    req1 = 1'b0;
                    lock1 = 1'b0;
                end
                if (done0) req0 = 1'b0;
            end
            check("lock_port0_served", 32'(done0), 32'(1));
        end
`endif

        repeat (3) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
